pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the pipeline: it owns the program counter, addresses the instruction ROM, and latches the fetched word plus its incremented PC into the IF/ID pipeline register. It supplies the `pc_next` value that the branch-target adder downstream uses. It also consumes that adder's `branch_pc` result to redirect fetch on a taken branch, with a one-bubble flush. A two-state FSM stops fetch on a HALT word until a branch redirect or reset.

## Interface
- `PC_WIDE`, default 7: width of PC and instruction address; matches branch-target adder.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hazard unit hold request; freezes PC and IF/ID.
- `branch_taken` input 1: redirect request from branch resolution.
- `branch_pc` input PC_WIDE: redirect target, from branch-target adder.
- `imem_addr` output PC_WIDE: ROM address, combinationally equal to PC register.
- `imem_rdata` input 32: ROM word at `imem_addr`, combinational (same-cycle) read.
- `ifid_instr` output 32: latched instruction.
- `ifid_pc_next` output PC_WIDE: latched PC+1 of that instruction.
- `ifid_valid` output 1: IF/ID holds a real instruction.
- `halted` output 1: FSM in HALT.

## Operation
- FSM states FETCH, HALT; reset → FETCH.
- Per-edge priority: `rst` > `branch_taken` > `stall` > normal.
- rst: pc=0, ifid_instr=NOP_INSTR (32'h0), ifid_pc_next=0, ifid_valid=0, state=FETCH, halted=0.
- branch_taken (any state, stall ignored): pc←branch_pc; ifid_instr←NOP, ifid_valid←0, ifid_pc_next←0; state←FETCH.
- stall (no branch): pc, IF/ID, state all hold.
- FETCH normal: ifid_instr←imem_rdata, ifid_pc_next←pc+1, ifid_valid←1, pc←pc+1. If imem_rdata==HALT_INSTR (32'hFFFF_FFFF): HALT word still latched valid, pc holds (no increment), state←HALT.
- HALT normal: pc holds; ifid_valid←0, ifid_instr←NOP.
- Arithmetic: pc+1 modulo 2^PC_WIDE; pc=2^PC_WIDE−1 wraps to 0, ifid_pc_next=0. branch_pc used as-is, no range check.

## Timing
- Fetch latency: instruction at address A visible on ifid_* the edge after pc==A.
- First valid: rst deasserted at edge 0 → ifid_valid=1 with address-0 word after edge 1.
- Branch penalty: exactly one bubble (ifid_valid=0 for one cycle) after the redirect edge; target word valid on the following edge if not stalled.
- stall and branch_taken same cycle: branch wins, flush occurs.
- rst mid-stall/mid-HALT: full reset on that edge, no residual state.
- halted asserts the edge the HALT word is latched; deasserts on redirect/reset edge.
- Throughput: one instruction per cycle in FETCH with no stall.

## Configuration
- `PC_FETCH_PERF_EN`: when defined, adds outputs `perf_fetched` (32) and `perf_bubbles` (32). perf_fetched counts edges loading ifid_valid←1; perf_bubbles counts edges loading ifid_valid←0 outside reset. Both are cleared by rst, hold under stall, and wrap at 2^32. When undefined, the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pc_fetch_pkg`: NOP_INSTR, HALT_INSTR, FSM state encoding (FETCH=0, HALT=1).
- One sub-module `ifid_reg`: IF/ID register with load/flush/hold controls; PC, FSM, and counters stay in `pc_fetch`.

## Test plan
- Reset then free-run, ROM[i]=i+100: ifid_instr 100,101,102…; ifid_pc_next 1,2,3…; ifid_valid=1 from edge 1.
- stall high 3 cycles at pc=5: pc and ifid_* frozen (instr 104, pc_next 5); resumes with 105.
- branch_taken with branch_pc=40 at pc=10: one cycle ifid_valid=0, instr=0; then ROM[40] with pc_next 41.
- PC_WIDE=7, pc reaches 127: ifid_pc_next=0, next fetch from address 0.
- ROM[3]=32'hFFFF_FFFF: HALT word latched valid, halted=1, pc stays 3, ifid_valid=0 thereafter. A later branch to 20 clears halted and fetches ROM[20].
- branch_taken and stall together, then rst asserted during HALT: branch wins and flushes; rst returns pc=0, ifid_valid=0, halted=0 (perf counters 0 when `PC_FETCH_PERF_EN`).

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared constants and types for the instruction-fetch stage.
//   NOP_INSTR  : word placed in IF/ID when it holds no real instruction.
//   HALT_INSTR : fetched word that stops the fetch FSM.
//   fetch_state_t : fetch FSM encoding (FETCH=0, HALT=1).
package pc_fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_ifid_reg.sv
// ifid_reg
//   IF/ID pipeline register. Priority per edge: rst/flush > load > hold.
//   A flush (or reset) loads a bubble: NOP word, zero pc_next, valid low.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     load                : capture instr_in/pc_next_in as a valid entry
//     flush               : replace contents with a bubble
//     instr_in, pc_next_in: data to capture on load
//     instr, pc_next, valid: registered IF/ID contents
module ifid_reg
    import pc_fetch_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic [31:0]  instr_in,
    input  logic [W-1:0] pc_next_in,
    output logic [31:0]  instr,
    output logic [W-1:0] pc_next,
    output logic         valid
);

    logic [31:0]  instr_reg;
    logic [W-1:0] pc_next_reg;
    logic         valid_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_reg   <= NOP_INSTR;
            pc_next_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (load) begin
            instr_reg   <= instr_in;
            pc_next_reg <= pc_next_in;
            valid_reg   <= 1'b1;
        end
    end

    assign instr   = instr_reg;
    assign pc_next = pc_next_reg;
    assign valid   = valid_reg;

endmodule : ifid_reg

// File: rtl/pc_fetch.sv
// pc_fetch
//   Instruction-fetch stage: owns the PC, addresses the instruction ROM and
//   fills the IF/ID register. A taken branch redirects the PC and flushes
//   IF/ID (one bubble). Fetching the HALT word parks the FSM in HALT until a
//   branch redirect or reset.
//   Edge priority: rst > branch_taken > stall > normal operation.
//   Optional build macro PC_FETCH_PERF_EN adds perf_fetched / perf_bubbles.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     stall           : hold PC, IF/ID and FSM state
//     branch_taken    : redirect fetch to branch_pc (overrides stall)
//     branch_pc       : redirect target
//     imem_addr       : ROM address (= PC register)
//     imem_rdata      : ROM word at imem_addr, same-cycle
//     ifid_instr      : latched instruction
//     ifid_pc_next    : latched PC+1 of that instruction
//     ifid_valid      : IF/ID holds a real instruction
//     halted          : FSM is in HALT
//     perf_fetched    : (PC_FETCH_PERF_EN) edges loading a valid entry
//     perf_bubbles    : (PC_FETCH_PERF_EN) edges loading a bubble
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int PC_WIDE = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_WIDE-1:0] branch_pc,
    output logic [PC_WIDE-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ifid_instr,
    output logic [PC_WIDE-1:0] ifid_pc_next,
    output logic               ifid_valid,
    output logic               halted
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    fetch_state_t       state_reg, state_next;
    logic [PC_WIDE-1:0] pc_reg, pc_next;
    logic [PC_WIDE-1:0] pc_plus1;
    logic               ifid_load;
    logic               ifid_flush;

    // Natural wrap modulo 2^PC_WIDE.
    assign pc_plus1 = pc_reg + PC_WIDE'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (branch_taken) begin
            // Redirect wins over stall and leaves HALT.
            pc_next    = branch_pc;
            ifid_flush = 1'b1;
            state_next = FETCH;
        end else if (!stall) begin
            case (state_reg)
                FETCH: begin
                    ifid_load = 1'b1;
                    // The HALT word is still delivered downstream, but the PC
                    // stays on it so nothing beyond it is fetched.
                    if (imem_rdata == HALT_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc_plus1;
                    end
                end
                HALT: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    ifid_reg #(
        .W(PC_WIDE)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .instr_in  (imem_rdata),
        .pc_next_in(pc_plus1),
        .instr     (ifid_instr),
        .pc_next   (ifid_pc_next),
        .valid     (ifid_valid)
    );

    assign imem_addr = pc_reg;
    assign halted    = (state_reg == HALT);

`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_bubbles_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_bubbles_reg <= '0;
        end else begin
            if (ifid_load) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (ifid_flush) begin
                perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch
//   Directed, table-driven bench for pc_fetch (PC_WIDE=7). The ROM is a
//   bench array with ROM[i]=i+100; each step drives inputs just after a
//   rising edge and checks IF/ID, halted and the ROM address 1 ns after the
//   next rising edge. One line is printed per step.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         branch_taken;
    logic [W-1:0] branch_pc;
    logic [W-1:0] imem_addr;
    logic [31:0]  imem_rdata;
    logic [31:0]  ifid_instr;
    logic [W-1:0] ifid_pc_next;
    logic         ifid_valid;
    logic         halted;
`ifdef PC_FETCH_PERF_EN
    logic [31:0]  perf_fetched;
    logic [31:0]  perf_bubbles;
`endif

    logic [31:0] rom [0:(1<<W)-1];
    assign imem_rdata = rom[imem_addr];

    int checks;
    int failures;

    pc_fetch #(
        .PC_WIDE(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_pc   (branch_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_pc_next(ifid_pc_next),
        .ifid_valid  (ifid_valid),
        .halted      (halted)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         stall;
        logic         br;
        logic [W-1:0] bpc;
        logic [31:0]  instr;
        logic [W-1:0] pcn;
        logic         valid;
        logic         halted;
        logic [W-1:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [W-1:0] bpc, input logic [31:0] ei,
                                input logic [W-1:0] epn, input logic ev,
                                input logic eh, input logic [W-1:0] epc);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.bpc = bpc;
        v.instr = ei; v.pcn = epn; v.valid = ev; v.halted = eh; v.pc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one set of inputs for one edge and compare the result.
    task automatic step(input string tag, input vec_t v);
        rst = v.rst; stall = v.stall; branch_taken = v.br; branch_pc = v.bpc;
        @(posedge clk);
        #1;
        check({tag, ".instr"},  ifid_instr, v.instr);
        check({tag, ".pc_next"}, 32'(ifid_pc_next), 32'(v.pcn));
        check({tag, ".valid"},  32'(ifid_valid), 32'(v.valid));
        check({tag, ".halted"}, 32'(halted), 32'(v.halted));
        check({tag, ".pc"},     32'(imem_addr), 32'(v.pc));
        $display("%s rst=%0b stall=%0b br=%0b bpc=%0d -> instr=%0h pcn=%0d valid=%0b halted=%0b pc=%0d",
                 tag, v.rst, v.stall, v.br, v.bpc, ifid_instr, ifid_pc_next,
                 ifid_valid, halted, imem_addr);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
        for (int i = 0; i < (1 << W); i++) rom[i] = 32'(i + 100);

        // Reset, free run, stall at pc=5, branch at pc=10, branch+stall, wrap.
        vecs.push_back(mk(1, 0, 0, 0,  32'd0,   0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 32'(100 + i), W'(i + 1), 1, 0, W'(i + 1)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 0, 0, 32'd104, 5, 1, 0, 5));
        for (int i = 5; i < 10; i++)
            vecs.push_back(mk(0, 0, 0, 0, 32'(100 + i), W'(i + 1), 1, 0, W'(i + 1)));
        vecs.push_back(mk(0, 0, 1, 40,  32'd0,   0,   0, 0, 40));
        vecs.push_back(mk(0, 0, 0, 0,   32'd140, 41,  1, 0, 41));
        vecs.push_back(mk(0, 1, 1, 125, 32'd0,   0,   0, 0, 125));
        vecs.push_back(mk(0, 0, 0, 0,   32'd225, 126, 1, 0, 126));
        vecs.push_back(mk(0, 0, 0, 0,   32'd226, 127, 1, 0, 127));
        vecs.push_back(mk(0, 0, 0, 0,   32'd227, 0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   32'd100, 1,   1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // HALT handling: ROM[3] holds the HALT word.
        rom[3] = HALT_INSTR;
        step("h_rst",    mk(1, 0, 0, 0,  32'd0,   0,  0, 0, 0));
        step("h_f0",     mk(0, 0, 0, 0,  32'd100, 1,  1, 0, 1));
        step("h_f1",     mk(0, 0, 0, 0,  32'd101, 2,  1, 0, 2));
        step("h_f2",     mk(0, 0, 0, 0,  32'd102, 3,  1, 0, 3));
        step("h_halt",   mk(0, 0, 0, 0,  HALT_INSTR, 4, 1, 1, 3));
        step("h_idle0",  mk(0, 0, 0, 0,  32'd0,   0,  0, 1, 3));
        step("h_idle1",  mk(0, 0, 0, 0,  32'd0,   0,  0, 1, 3));
        step("h_stall",  mk(0, 1, 0, 0,  32'd0,   0,  0, 1, 3));
        step("h_br20",   mk(0, 0, 1, 20, 32'd0,   0,  0, 0, 20));
        step("h_f20",    mk(0, 0, 0, 0,  32'd120, 21, 1, 0, 21));
        // Re-enter HALT, then reset while halted and stalled.
        step("h_br2",    mk(0, 1, 1, 2,  32'd0,   0,  0, 0, 2));
        step("h_f2b",    mk(0, 0, 0, 0,  32'd102, 3,  1, 0, 3));
        step("h_halt2",  mk(0, 0, 0, 0,  HALT_INSTR, 4, 1, 1, 3));
        step("h_rst2",   mk(1, 1, 0, 0,  32'd0,   0,  0, 0, 0));
`ifdef PC_FETCH_PERF_EN
        check("perf_fetched_rst", perf_fetched, 32'd0);
        check("perf_bubbles_rst", perf_bubbles, 32'd0);
        step("p_f0",     mk(0, 0, 0, 0,  32'd100, 1,  1, 0, 1));
        step("p_br",     mk(0, 0, 1, 9,  32'd0,   0,  0, 0, 9));
        step("p_stall",  mk(0, 1, 0, 0,  32'd0,   0,  0, 0, 9));
        check("perf_fetched_run", perf_fetched, 32'd1);
        check("perf_bubbles_run", perf_bubbles, 32'd1);
`endif
        // After reset the ROM word at 0 is fetched normally again.
        step("h_after",  mk(1, 0, 0, 0,  32'd0,   0,  0, 0, 0));
        step("h_after1", mk(0, 0, 0, 0,  32'd100, 1,  1, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_fetch
